// File: rtl/flit_sink_checker.sv
// Ejection-side sink: accepts flits, counts them against a configured total and checks dst/src/framing/sequence.
// Optional macro SINK_BACKPRESSURE_EN adds LFSR-driven stall cycles on io_in_ready.
module flit_sink_checker #(
    parameter int unsigned MY_ID   = 0,
    parameter int unsigned NUM_SRC = 3,
    parameter int unsigned ID_W    = 2,
    parameter int unsigned FLIT_W  = 55
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_config_valid,
    output logic              io_config_ready,
    input  logic [31:0]       io_config_bits_count,
    input  logic              io_in_valid,
    output logic              io_in_ready,
    input  logic [FLIT_W-1:0] io_in_bits,
    output logic [31:0]       io_count,
    output logic [15:0]       io_err_count,
    output logic              io_done,
    output logic [FLIT_W-1:0] io_dump
);

    localparam int unsigned NSLOT  = 2 ** ID_W;
    localparam int unsigned HEAD_B = FLIT_W - 1;
    localparam int unsigned TAIL_B = FLIT_W - 2;
    localparam int unsigned SRC_HI = FLIT_W - 3;
    localparam int unsigned SRC_LO = SRC_HI - ID_W + 1;
    localparam int unsigned DST_HI = SRC_LO - 1;
    localparam int unsigned DST_LO = DST_HI - ID_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic              r_cfg_ready;
    logic              r_in_ready;
    logic              r_done;
    logic [31:0]       r_exp_total;
    logic [31:0]       r_count;
    logic [15:0]       r_err_count;
    logic [FLIT_W-1:0] r_dump;
    logic [31:0]       r_exp_num [NSLOT];
    logic [NSLOT-1:0]  r_in_pkt;

    logic              w_cfg_fire;
    logic              w_xfer;
    logic              w_bp_ok;
    logic              w_head;
    logic              w_tail;
    logic [ID_W-1:0]   w_src;
    logic [ID_W-1:0]   w_dst;
    logic [31:0]       w_payload;
    logic              w_src_ok;
    logic              w_err;

    assign w_cfg_fire = io_config_valid && r_cfg_ready;
    assign w_xfer     = io_in_valid && r_in_ready;

    assign w_head    = io_in_bits[HEAD_B];
    assign w_tail    = io_in_bits[TAIL_B];
    assign w_src     = io_in_bits[SRC_HI:SRC_LO];
    assign w_dst     = io_in_bits[DST_HI:DST_LO];
    assign w_payload = io_in_bits[31:0];
    assign w_src_ok  = 32'(w_src) < NUM_SRC;

    // One error per flit no matter how many checks it trips
    assign w_err = (w_dst != ID_W'(MY_ID)) || !w_src_ok
                || (w_src_ok && (w_head == r_in_pkt[w_src]))
                || (w_src_ok && (w_payload != r_exp_num[w_src]));

`ifdef SINK_BACKPRESSURE_EN
    logic [15:0] r_lfsr;
    logic [15:0] w_lfsr_nxt;

    assign w_lfsr_nxt = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[15:1]};
    assign w_bp_ok    = (w_lfsr_nxt[1:0] != 2'b00);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_lfsr <= 16'hACE1;
        end else begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`else
    assign w_bp_ok = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_cfg_fire) w_state_nxt = S_RUN;
            S_RUN:   if (r_count == r_exp_total) w_state_nxt = S_DONE;
            S_DONE:  if (w_cfg_fire) w_state_nxt = S_RUN;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake/status flags registered from the next state so they match the state each cycle
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_cfg_ready <= 1'b1;
            r_in_ready  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_cfg_ready <= (w_state_nxt != S_RUN);
            r_in_ready  <= (w_state_nxt == S_RUN) && w_bp_ok;
            r_done      <= (w_state_nxt == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_exp_total <= '0;
            r_count     <= '0;
            r_err_count <= '0;
            r_dump      <= '0;
            r_in_pkt    <= '0;
            for (int i = 0; i < NSLOT; i++) r_exp_num[i] <= '0;
        end else if (w_cfg_fire) begin
            r_exp_total <= io_config_bits_count;
            r_count     <= '0;
            r_err_count <= '0;
            r_dump      <= '0;
            r_in_pkt    <= '0;
            for (int i = 0; i < NSLOT; i++) r_exp_num[i] <= '0;
        end else if (w_xfer) begin
            r_count <= r_count + 32'd1;
            if (w_err) begin
                if (r_err_count == 16'd0) r_dump <= io_in_bits;
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
            // Source tracking resynchronises on every flit from a legal source
            if (w_src_ok) begin
                r_exp_num[w_src] <= w_payload + 32'd1;
                if (w_tail) begin
                    r_in_pkt[w_src] <= 1'b0;
                end else if (w_head) begin
                    r_in_pkt[w_src] <= 1'b1;
                end
            end
        end
    end

    assign io_config_ready = r_cfg_ready;
    assign io_in_ready     = r_in_ready;
    assign io_done         = r_done;
    assign io_count        = r_count;
    assign io_err_count    = r_err_count;
    assign io_dump         = r_dump;

endmodule

// File: tb/tb_flit_sink_checker.sv
// Directed and randomized checks of flit_sink_checker against a flit-level reference model.
module tb_flit_sink_checker;

    localparam int unsigned FLIT_W  = 55;
    localparam int unsigned MY_ID   = 0;
    localparam int unsigned NUM_SRC = 3;

    logic              clk;
    logic              reset;
    logic              io_config_valid;
    logic              io_config_ready;
    logic [31:0]       io_config_bits_count;
    logic              io_in_valid;
    logic              io_in_ready;
    logic [FLIT_W-1:0] io_in_bits;
    logic [31:0]       io_count;
    logic [15:0]       io_err_count;
    logic              io_done;
    logic [FLIT_W-1:0] io_dump;

    flit_sink_checker #(
        .MY_ID(MY_ID), .NUM_SRC(NUM_SRC), .ID_W(2), .FLIT_W(FLIT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .io_config_valid(io_config_valid),
        .io_config_ready(io_config_ready),
        .io_config_bits_count(io_config_bits_count),
        .io_in_valid(io_in_valid),
        .io_in_ready(io_in_ready),
        .io_in_bits(io_in_bits),
        .io_count(io_count),
        .io_err_count(io_err_count),
        .io_done(io_done),
        .io_dump(io_dump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int stalls = 0;

    // Reference model: expected next number and packet-open flag per source id
    logic [31:0]       m_exp [4];
    bit                m_inpkt [4];
    int unsigned       m_count;
    int unsigned       m_err;
    logic [FLIT_W-1:0] m_dump;

    function automatic logic [FLIT_W-1:0] mk(input bit h, input bit t, input int src,
                                             input int dst, input logic [31:0] pl);
        logic [FLIT_W-1:0] f;
        f = {h, t, 2'(src), 2'(dst), 17'd0, pl};
        return f;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_count = 0;
        m_err   = 0;
        m_dump  = '0;
        for (int i = 0; i < 4; i++) begin
            m_exp[i]   = '0;
            m_inpkt[i] = 1'b0;
        end
    endtask

    task automatic model_accept(input logic [FLIT_W-1:0] f);
        bit h, t, bad;
        int src, dst;
        logic [31:0] pl;
        h   = f[54];
        t   = f[53];
        src = int'(f[52:51]);
        dst = int'(f[50:49]);
        pl  = f[31:0];
        m_count++;
        bad = (dst != int'(MY_ID));
        if (src >= int'(NUM_SRC)) begin
            bad = 1'b1;
        end else begin
            if (h && m_inpkt[src]) bad = 1'b1;
            if (!h && !m_inpkt[src]) bad = 1'b1;
            if (pl != m_exp[src]) bad = 1'b1;
            m_exp[src] = pl + 32'd1;
            if (t) m_inpkt[src] = 1'b0;
            else if (h) m_inpkt[src] = 1'b1;
        end
        if (bad) begin
            if (m_err == 0) m_dump = f;
            if (m_err < 65535) m_err++;
        end
    endtask

    task automatic cfg(input logic [31:0] cnt);
        bit ok;
        ok = 1'b0;
        io_config_valid      = 1'b1;
        io_config_bits_count = cnt;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk);
            if (io_config_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        io_config_valid = 1'b0;
        chk("cfg_handshake", 64'(ok), 64'd1);
        model_clear();
    endtask

    task automatic send(input logic [FLIT_W-1:0] f);
        bit ok;
        ok = 1'b0;
        io_in_valid = 1'b1;
        io_in_bits  = f;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (io_in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end else begin
                stalls++;
            end
        end
        io_in_valid = 1'b0;
        if (ok) model_accept(f);
        else chk("send_timeout", 64'(ok), 64'd1);
    endtask

    task automatic wait_done();
        for (int k = 0; k < 50 && !io_done; k++) begin
            @(posedge clk);
            #1;
        end
        chk("done", 64'(io_done), 64'd1);
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_count"}, 64'(io_count), 64'(m_count));
        chk({tag, "_err"}, 64'(io_err_count), 64'(m_err));
        chk({tag, "_dump"}, 64'(io_dump), 64'(m_dump));
        chk({tag, "_cfg_ready"}, 64'(io_config_ready), 64'd1);
        chk({tag, "_in_ready"}, 64'(io_in_ready), 64'd0);
    endtask

    task automatic rand_run(input int n, input bit inject);
        int rem [3];
        logic [31:0] nxt [3];
        int s, src, dst, len;
        bit h, t;
        logic [31:0] pl;
        for (int i = 0; i < 3; i++) begin
            rem[i] = 0;
            nxt[i] = '0;
        end
        cfg(32'(n));
        for (int i = 0; i < n; i++) begin
            s = int'($urandom_range(0, 2));
            h = 1'b0;
            if (rem[s] == 0) begin
                len    = int'($urandom_range(1, 4));
                rem[s] = len;
                h      = 1'b1;
            end
            rem[s]--;
            t   = (rem[s] == 0);
            pl  = nxt[s];
            nxt[s]++;
            src = s;
            dst = int'(MY_ID);
            if (inject && $urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: dst = dst ^ 1;
                    1: src = 3;
                    2: pl  = pl + 32'd5;
                    default: h = ~h;
                endcase
            end
            send(mk(h, t, src, dst, pl));
        end
        wait_done();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset                = 1'b0;
        io_config_valid      = 1'b0;
        io_config_bits_count = '0;
        io_in_valid          = 1'b0;
        io_in_bits           = '0;
        model_clear();

        // Reset state
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        chk("rst_cfg_ready", 64'(io_config_ready), 64'd1);
        chk("rst_in_ready", 64'(io_in_ready), 64'd0);
        chk("rst_count", 64'(io_count), 64'd0);
        chk("rst_err", 64'(io_err_count), 64'd0);
        chk("rst_dump", 64'(io_dump), 64'd0);
        chk("rst_done", 64'(io_done), 64'd0);

        // Two clean 4-flit packets from source 0
        cfg(32'd8);
        for (int i = 0; i < 8; i++) send(mk((i % 4) == 0, (i % 4) == 3, 0, int'(MY_ID), 32'(i)));
        chk("t2_count_now", 64'(io_count), 64'd8);
        chk("t2_done_early", 64'(io_done), 64'd0);
        @(posedge clk);
        #1;
        chk("t2_done_next", 64'(io_done), 64'd1);
        check_run("t2");

        // Sequence gap on source 1
        cfg(32'd4);
        send(mk(1, 0, 1, int'(MY_ID), 32'd0));
        send(mk(0, 0, 1, int'(MY_ID), 32'd1));
        send(mk(0, 0, 1, int'(MY_ID), 32'd3));
        send(mk(0, 1, 1, int'(MY_ID), 32'd4));
        wait_done();
        check_run("t3");
        chk("t3_err_const", 64'(io_err_count), 64'd1);
        chk("t3_dump_const", 64'(io_dump), 64'(mk(0, 0, 1, int'(MY_ID), 32'd3)));

        // Wrong destination, then head inside an open packet on source 2
        cfg(32'd3);
        send(mk(1, 0, 2, int'(MY_ID) + 1, 32'd0));
        send(mk(1, 0, 2, int'(MY_ID), 32'd1));
        send(mk(0, 1, 2, int'(MY_ID), 32'd2));
        wait_done();
        check_run("t4");
        chk("t4_err_const", 64'(io_err_count), 64'd2);
        chk("t4_dump_const", 64'(io_dump), 64'(mk(1, 0, 2, int'(MY_ID) + 1, 32'd0)));

        // Reset in the middle of an open packet
        cfg(32'd10);
        for (int i = 0; i < 5; i++) send(mk(i == 0, 0, 0, int'(MY_ID), 32'(i)));
        chk("t5_mid_count", 64'(io_count), 64'd5);
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("t5_rst_count", 64'(io_count), 64'd0);
        chk("t5_rst_err", 64'(io_err_count), 64'd0);
        chk("t5_rst_dump", 64'(io_dump), 64'd0);
        chk("t5_rst_done", 64'(io_done), 64'd0);
        chk("t5_rst_cfg_ready", 64'(io_config_ready), 64'd1);
        chk("t5_rst_in_ready", 64'(io_in_ready), 64'd0);
        reset = 1'b1;
        model_clear();
        cfg(32'd1);
        send(mk(1, 1, 0, int'(MY_ID), 32'd0));
        wait_done();
        check_run("t5");

        // Zero-length run completes on its own
        cfg(32'd0);
        wait_done();
        check_run("t6_zero");

        // Clean interleaved traffic from all sources
        stalls = 0;
        rand_run(1000, 1'b0);
        check_run("t7");
        chk("t7_err_zero", 64'(io_err_count), 64'd0);
`ifdef SINK_BACKPRESSURE_EN
        chk("t7_stall_seen", 64'(stalls > 0), 64'd1);
`endif

        // Random traffic with injected faults
        rand_run(200, 1'b1);
        check_run("t8");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
